// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from the instruction cache,
// buffers one word across decode stalls, and handles redirects and HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] Instr,
    output logic [15:0] pc_plus2,
    output logic        valid,
    output logic        halted
);

    localparam int unsigned W     = 16;
    localparam int unsigned OPC_W = 5;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t         state, state_d;
    logic [W-1:0]   pc, pc_d;
    logic [W-1:0]   drain_addr, drain_addr_d;
    logic [W-1:0]   buf_instr, buf_instr_d;
    logic [W-1:0]   buf_pc2, buf_pc2_d;
    logic [W-1:0]   instr_d, pc_plus2_d;
    logic           valid_d, halted_d;
    logic           issue;
    logic [W-1:0]   issue_instr, issue_pc2;

    // Request side: DRAIN keeps presenting the abandoned address until the cache finishes it.
    assign imem_rd   = !rst && (state == S_FETCH || state == S_WAIT || state == S_DRAIN);
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;

    // Next-state and datapath.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        drain_addr_d = drain_addr;
        buf_instr_d  = buf_instr;
        buf_pc2_d    = buf_pc2;
        instr_d      = Instr;
        pc_plus2_d   = pc_plus2;
        valid_d      = valid;
        halted_d     = halted;
        issue        = 1'b0;
        issue_instr  = imem_data;
        issue_pc2    = pc + W'(2);

        unique case (state)
            S_FETCH, S_WAIT: begin
                if (imem_done) begin
                    pc_d = pc + W'(2);
                    if (stall_in) begin
                        buf_instr_d = imem_data;
                        buf_pc2_d   = pc + W'(2);
                        state_d     = S_HOLD;
                    end else begin
                        issue   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (!stall_in) begin
                    issue       = 1'b1;
                    issue_instr = buf_instr;
                    issue_pc2   = buf_pc2;
                    state_d     = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (issue) begin
            instr_d    = issue_instr;
            pc_plus2_d = issue_pc2;
            valid_d    = 1'b1;
            if (issue_instr[W-1 -: OPC_W] == OPC_W'(0)) begin
                halted_d = 1'b1;
                state_d  = S_HALTED;
            end
        end else if (!stall_in) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        // Redirect squashes everything; an unfinished request must still be drained.
        if (redirect) begin
            pc_d     = redirect_pc;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            if (state == S_DRAIN) begin
                state_d = imem_done ? S_FETCH : S_DRAIN;
            end else if ((state == S_FETCH || state == S_WAIT) && !imem_done) begin
                drain_addr_d = pc;
                state_d      = S_DRAIN;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            buf_instr  <= '0;
            buf_pc2    <= '0;
            Instr      <= NOP_INSTR;
            pc_plus2   <= '0;
            valid      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            drain_addr <= drain_addr_d;
            buf_instr  <= buf_instr_d;
            buf_pc2    <= buf_pc2_d;
            Instr      <= instr_d;
            pc_plus2   <= pc_plus2_d;
            valid      <= valid_d;
            halted     <= halted_d;
        end
    end

endmodule
